csi2tx_lane_sched_ctrl: RTL and testbench

Sequencing controller for the CSI-2 TX lane management layer. It selects which lane distribution layer is active (1, 2, 4 or 8 lanes) and times the D-PHY init (TINIT) period. It gates enable_hs_transmission and owns the HS-exit countdown. It also aggregates per-lane stop-state into the single stop_state_dl consumed by the active distribution layer.

---
 rtl/csi2tx_defines.sv | 46 ++++
 rtl/csi2tx_hs_exit_timer.sv | 29 ++
 rtl/csi2tx_lane_sched_ctrl.sv | 133 +++++++++++++
 tb/tb_csi2tx_lane_sched_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi2tx_defines.sv
// Shared encodings for the CSI-2 TX lane management layer: lane configurations,
// scheduler states and the lane_cfg -> lane enable / lane mask decode.
package csi2tx_defines;

  typedef enum logic [1:0] {
    LANE_CFG_1 = 2'b00,
    LANE_CFG_2 = 2'b01,
    LANE_CFG_4 = 2'b10,
    LANE_CFG_8 = 2'b11
  } lane_cfg_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_APPLY = 2'd2,
    ST_BUSY  = 2'd3
  } sched_state_e;

  localparam logic [3:0] LANE_EN_1   = 4'b0001;
  localparam logic [3:0] LANE_EN_2   = 4'b0010;
  localparam logic [3:0] LANE_EN_4   = 4'b0100;
  localparam logic [3:0] LANE_EN_8   = 4'b1000;
  localparam logic [7:0] LANE_MASK_1 = 8'h01;
  localparam logic [7:0] LANE_MASK_2 = 8'h03;
  localparam logic [7:0] LANE_MASK_4 = 8'h0F;
  localparam logic [7:0] LANE_MASK_8 = 8'hFF;

  function automatic logic [3:0] lane_en_decode(input logic [1:0] cfg);
    case (cfg)
      LANE_CFG_1: lane_en_decode = LANE_EN_1;
      LANE_CFG_2: lane_en_decode = LANE_EN_2;
      LANE_CFG_4: lane_en_decode = LANE_EN_4;
      default:    lane_en_decode = LANE_EN_8;
    endcase
  endfunction

  function automatic logic [7:0] lane_mask_decode(input logic [1:0] cfg);
    case (cfg)
      LANE_CFG_1: lane_mask_decode = LANE_MASK_1;
      LANE_CFG_2: lane_mask_decode = LANE_MASK_2;
      LANE_CFG_4: lane_mask_decode = LANE_MASK_4;
      default:    lane_mask_decode = LANE_MASK_8;
    endcase
  endfunction

endpackage

// File: rtl/csi2tx_hs_exit_timer.sv
// Loadable down-counter that saturates at zero; expired_o flags a zero count
// while the count is being consumed.
module csi2tx_hs_exit_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic         decr_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                     cnt_d = load_val_i;
    else if (decr_i && cnt_q != '0) cnt_d = cnt_q - W'(1);
  end

  assign expired_o = decr_i && (cnt_q == '0);

endmodule

// File: rtl/csi2tx_lane_sched_ctrl.sv
// Lane scheduling controller: TINIT timing, lane-configuration apply, HS
// transmission gating, HS-exit timing and stop-state aggregation.
module csi2tx_lane_sched_ctrl
  import csi2tx_defines::*;
#(
  parameter int TINIT_W  = 16,
  parameter int HSEXIT_W = 8
) (
  input  logic                txbyteclkhs,
  input  logic                txbyteclkhs_rst_n,
  input  logic [1:0]          lane_cfg,
  input  logic                cfg_update,
  input  logic [TINIT_W-1:0]  tinit_cnt_val,
  input  logic [HSEXIT_W-1:0] hs_exit_cnt_val,
  input  logic                forcetxstopmode,
  input  logic                csi_byte_fifo_empty,
  input  logic [7:0]          stopstate_data,
  input  logic                tx_done,
  input  logic                hs_exit_cnt_decr_enable,
  output logic [3:0]          lane_en,
  output logic [7:0]          active_lane_mask,
  output logic                tinit_start,
  output logic                enable_hs_transmission,
  output logic                stop_state_dl,
  output logic                hs_exit_cnt_expired,
  output logic                busy
);

  sched_state_e        state_q, state_d;
  logic [TINIT_W-1:0]  tinit_q, tinit_d;
  logic                tinit_start_q, tinit_start_d;
  logic [1:0]          cfg_q, cfg_d;
  logic                cfg_pending_q, cfg_pending_d;
  logic [3:0]          lane_en_q, lane_en_d;
  logic [7:0]          mask_q, mask_d;
  logic                stop_q, stop_d;
  logic                hs_load;

  // tx_done only qualifies decisions in the distribution layer; not needed here.
  logic unused_tx_done;
  assign unused_tx_done = tx_done;

  // The TINIT count and lane selection are loaded straight from their inputs
  // while reset is held, so the first IDLE cycle applies the configured lanes.
  always_ff @(posedge txbyteclkhs or negedge txbyteclkhs_rst_n) begin
    if (!txbyteclkhs_rst_n) begin
      state_q       <= ST_INIT;
      tinit_q       <= tinit_cnt_val;
      tinit_start_q <= 1'b0;
      cfg_q         <= lane_cfg;
      cfg_pending_q <= 1'b1;
      lane_en_q     <= LANE_EN_1;
      mask_q        <= LANE_MASK_1;
      stop_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tinit_q       <= tinit_d;
      tinit_start_q <= tinit_start_d;
      cfg_q         <= cfg_d;
      cfg_pending_q <= cfg_pending_d;
      lane_en_q     <= lane_en_d;
      mask_q        <= mask_d;
      stop_q        <= stop_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    tinit_d       = tinit_q;
    tinit_start_d = tinit_start_q;
    cfg_d         = cfg_q;
    cfg_pending_d = cfg_pending_q;
    lane_en_d     = lane_en_q;
    mask_d        = mask_q;
    stop_d        = &(stopstate_data | ~mask_q);

    case (state_q)
      ST_INIT: begin
        if (tinit_q == '0) begin
          tinit_start_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          tinit_d = tinit_q - TINIT_W'(1);
        end
      end
      ST_IDLE: begin
        if (forcetxstopmode)          state_d = ST_IDLE;
        else if (cfg_pending_q)       state_d = ST_APPLY;
        else if (!csi_byte_fifo_empty) state_d = ST_BUSY;
      end
      ST_APPLY: begin
        state_d = ST_IDLE;
        if (!forcetxstopmode) begin
          lane_en_d     = lane_en_decode(cfg_q);
          mask_d        = lane_mask_decode(cfg_q);
          cfg_pending_d = 1'b0;
        end
      end
      ST_BUSY: begin
        if (forcetxstopmode || (hs_exit_cnt_decr_enable && hs_exit_cnt_expired))
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A fresh request always wins over the clear done by APPLY.
    if (cfg_update) begin
      cfg_d         = lane_cfg;
      cfg_pending_d = 1'b1;
    end
  end

  assign hs_load = !hs_exit_cnt_decr_enable || (forcetxstopmode && state_q != ST_INIT);

  csi2tx_hs_exit_timer #(
    .W(HSEXIT_W)
  ) u_hs_exit_timer (
    .clk_i      (txbyteclkhs),
    .rst_n_i    (txbyteclkhs_rst_n),
    .load_i     (hs_load),
    .decr_i     (hs_exit_cnt_decr_enable),
    .load_val_i (hs_exit_cnt_val),
    .expired_o  (hs_exit_cnt_expired)
  );

  assign lane_en                = lane_en_q;
  assign active_lane_mask       = mask_q;
  assign tinit_start            = tinit_start_q;
  assign stop_state_dl          = stop_q;
  assign busy                   = (state_q == ST_BUSY);
  assign enable_hs_transmission = (state_q == ST_IDLE) && !cfg_pending_q && !forcetxstopmode;

endmodule

// File: tb/tb_csi2tx_lane_sched_ctrl.sv
// Self-checking bench: directed sequences, a vector table for lane/stop-state
// decode, and a randomized run scored against a behavioural model.
module tb_csi2tx_lane_sched_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  lane_cfg;
  logic        cfg_update;
  logic [15:0] tinit_val;
  logic [7:0]  hs_val;
  logic        force_stop;
  logic        fifo_empty;
  logic [7:0]  stopstate;
  logic        tx_done;
  logic        decr;
  logic [3:0]  lane_en;
  logic [7:0]  mask;
  logic        tinit_start, enable_hs, stop_dl, expired, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csi2tx_lane_sched_ctrl #(.TINIT_W(16), .HSEXIT_W(8)) dut (
    .txbyteclkhs             (clk),
    .txbyteclkhs_rst_n       (rst_n),
    .lane_cfg                (lane_cfg),
    .cfg_update              (cfg_update),
    .tinit_cnt_val           (tinit_val),
    .hs_exit_cnt_val         (hs_val),
    .forcetxstopmode         (force_stop),
    .csi_byte_fifo_empty     (fifo_empty),
    .stopstate_data          (stopstate),
    .tx_done                 (tx_done),
    .hs_exit_cnt_decr_enable (decr),
    .lane_en                 (lane_en),
    .active_lane_mask        (mask),
    .tinit_start             (tinit_start),
    .enable_hs_transmission  (enable_hs),
    .stop_state_dl           (stop_dl),
    .hs_exit_cnt_expired     (expired),
    .busy                    (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: phases, lane count and remaining-time counters as integers.
  localparam int P_INIT = 0, P_IDLE = 1, P_APPLY = 2, P_BUSY = 3;
  int m_phase, m_tinit_left, m_lanes, m_cfg, m_hs_left;
  bit m_tinit_done, m_pending, m_stop;

  task automatic model_reset();
    m_phase      = P_INIT;
    m_tinit_left = int'(tinit_val);
    m_tinit_done = 0;
    m_lanes      = 1;
    m_cfg        = int'(lane_cfg);
    m_pending    = 1;
    m_hs_left    = 0;
    m_stop       = 0;
  endtask

  task automatic model_check(input int cyc);
    int exp_mask;
    exp_mask = (1 << m_lanes) - 1;
    chk($sformatf("r%0d lane_en", cyc), 32'(lane_en), 32'(1 << $clog2(m_lanes)));
    chk($sformatf("r%0d mask", cyc), 32'(mask), 32'(exp_mask));
    chk($sformatf("r%0d tinit_start", cyc), 32'(tinit_start), 32'(m_tinit_done));
    chk($sformatf("r%0d stop_dl", cyc), 32'(stop_dl), 32'(m_stop));
    chk($sformatf("r%0d busy", cyc), 32'(busy), 32'(m_phase == P_BUSY));
    chk($sformatf("r%0d enable_hs", cyc), 32'(enable_hs),
        32'(m_phase == P_IDLE && !m_pending && !force_stop));
    chk($sformatf("r%0d expired", cyc), 32'(expired), 32'(decr && m_hs_left == 0));
  endtask

  task automatic model_advance();
    int  old_cfg, exp_mask;
    bit  exp_now;
    old_cfg  = m_cfg;
    exp_mask = (1 << m_lanes) - 1;
    exp_now  = decr && m_hs_left == 0;
    m_stop   = ((int'(stopstate) & exp_mask) == exp_mask);
    case (m_phase)
      P_INIT: begin
        if (m_tinit_left == 0) begin
          m_tinit_done = 1;
          m_phase      = P_IDLE;
        end else m_tinit_left--;
      end
      P_IDLE: begin
        if (force_stop)      m_phase = P_IDLE;
        else if (m_pending)  m_phase = P_APPLY;
        else if (!fifo_empty) m_phase = P_BUSY;
      end
      P_APPLY: begin
        m_phase = P_IDLE;
        if (!force_stop) begin
          m_lanes   = 1 << old_cfg;
          m_pending = 0;
        end
      end
      default: begin
        if (force_stop || exp_now) m_phase = P_IDLE;
      end
    endcase
    if (!decr || (force_stop && m_phase_was_not_init(old_cfg)))
      m_hs_left = int'(hs_val);
    else if (m_hs_left > 0)
      m_hs_left--;
    if (cfg_update) begin
      m_cfg     = int'(lane_cfg);
      m_pending = 1;
    end
  endtask

  // Tracks whether the phase that just ended was INIT (force is ignored there).
  bit m_prev_init;
  function automatic bit m_phase_was_not_init(input int unused_arg);
    return !m_prev_init;
  endfunction

  typedef struct {
    logic [1:0] cfg;
    logic [7:0] ss;
    logic [3:0] en;
    logic [7:0] mask;
    logic       stop;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'b01, 8'h03, 4'b0010, 8'h03, 1'b1};
    vecs[1] = '{2'b01, 8'h01, 4'b0010, 8'h03, 1'b0};
    vecs[2] = '{2'b11, 8'h7F, 4'b1000, 8'hFF, 1'b0};
    vecs[3] = '{2'b11, 8'hFF, 4'b1000, 8'hFF, 1'b1};
    vecs[4] = '{2'b00, 8'h01, 4'b0001, 8'h01, 1'b1};
    vecs[5] = '{2'b00, 8'hFE, 4'b0001, 8'h01, 1'b0};
    vecs[6] = '{2'b10, 8'hF7, 4'b0100, 8'h0F, 1'b0};
    vecs[7] = '{2'b01, 8'hFE, 4'b0010, 8'h03, 1'b0};

    rst_n = 1'b0; lane_cfg = 2'b10; cfg_update = 1'b0; tinit_val = 16'd5; hs_val = 8'd3;
    force_stop = 1'b0; fifo_empty = 1'b1; stopstate = 8'h00; tx_done = 1'b0; decr = 1'b0;
    m_prev_init = 1'b0;

    // Reset values and TINIT timing
    repeat (2) tick();
    chk("rst lane_en", 32'(lane_en), 32'h1);
    chk("rst mask", 32'(mask), 32'h01);
    chk("rst tinit_start", 32'(tinit_start), 0);
    chk("rst enable_hs", 32'(enable_hs), 0);
    chk("rst stop_dl", 32'(stop_dl), 0);
    chk("rst expired", 32'(expired), 0);
    chk("rst busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (5) tick();
    chk("tinit not yet", 32'(tinit_start), 0);
    tick();
    chk("tinit after 6", 32'(tinit_start), 1);
    chk("enable_hs pending", 32'(enable_hs), 0);
    tick();
    chk("apply lane_en old", 32'(lane_en), 32'h1);
    chk("apply enable_hs", 32'(enable_hs), 0);
    tick();
    chk("cfg10 lane_en", 32'(lane_en), 32'h4);
    chk("cfg10 mask", 32'(mask), 32'h0F);
    chk("idle enable_hs", 32'(enable_hs), 1);

    // BUSY and HS-exit with a count of 3
    fifo_empty = 1'b0; #1;
    chk("fifo enable_hs", 32'(enable_hs), 1);
    tick();
    chk("busy set", 32'(busy), 1);
    fifo_empty = 1'b1; decr = 1'b1; #1;
    chk("hs3 c1", 32'(expired), 0);
    tick(); chk("hs3 c2", 32'(expired), 0);
    tick(); chk("hs3 c3", 32'(expired), 0);
    tick(); chk("hs3 c4", 32'(expired), 1);
    tick(); decr = 1'b0;
    chk("hs exit busy", 32'(busy), 0);

    // Deferred cfg_update in BUSY, then HS-exit with a count of 0
    hs_val = 8'd0; fifo_empty = 1'b0;
    tick(); fifo_empty = 1'b1;
    lane_cfg = 2'b11; cfg_update = 1'b1;
    tick(); cfg_update = 1'b0;
    chk("defer lane_en a", 32'(lane_en), 32'h4);
    tick();
    chk("defer lane_en b", 32'(lane_en), 32'h4);
    decr = 1'b1; #1;
    chk("hs0 expired", 32'(expired), 1);
    tick(); decr = 1'b0;
    chk("defer idle busy", 32'(busy), 0);
    chk("defer idle enable", 32'(enable_hs), 0);
    tick();
    chk("defer apply enable", 32'(enable_hs), 0);
    chk("defer apply lane_en", 32'(lane_en), 32'h4);
    tick();
    chk("cfg11 lane_en", 32'(lane_en), 32'h8);
    chk("cfg11 mask", 32'(mask), 32'hFF);

    // Table: lane decode and stop-state aggregation
    for (int i = 0; i < 8; i++) begin
      lane_cfg = vecs[i].cfg; cfg_update = 1'b1;
      tick(); cfg_update = 1'b0;
      tick(); tick();
      stopstate = vecs[i].ss;
      tick();
      chk($sformatf("vec%0d lane_en", i), 32'(lane_en), 32'(vecs[i].en));
      chk($sformatf("vec%0d mask", i), 32'(mask), 32'(vecs[i].mask));
      chk($sformatf("vec%0d stop_dl", i), 32'(stop_dl), 32'(vecs[i].stop));
    end

    // forcetxstopmode mid-BUSY reloads the HS-exit count
    hs_val = 8'd4; fifo_empty = 1'b0;
    tick(); fifo_empty = 1'b1; decr = 1'b1;
    tick(); tick();
    force_stop = 1'b1;
    tick();
    chk("force busy", 32'(busy), 0);
    chk("force enable_hs", 32'(enable_hs), 0);
    chk("force reload", 32'(expired), 0);
    force_stop = 1'b0; #1;
    chk("unforce enable_hs", 32'(enable_hs), 1);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk($sformatf("reload k%0d", k), 32'(expired), 32'(k == 4));
    end
    decr = 1'b0;
    tick();

    // Two pulses in BUSY: last one wins
    fifo_empty = 1'b0;
    tick(); fifo_empty = 1'b1;
    lane_cfg = 2'b01; cfg_update = 1'b1;
    tick(); lane_cfg = 2'b00;
    tick(); cfg_update = 1'b0;
    chk("double busy lane_en", 32'(lane_en), 32'h2);
    force_stop = 1'b1;
    tick(); force_stop = 1'b0; #1;
    chk("double pending enable", 32'(enable_hs), 0);
    tick(); tick();
    chk("double lane_en", 32'(lane_en), 32'h1);
    chk("double mask", 32'(mask), 32'h01);

    // Force during INIT does not stop the TINIT countdown
    rst_n = 1'b0; tinit_val = 16'd3; force_stop = 1'b1;
    tick(); rst_n = 1'b1;
    repeat (3) tick();
    chk("init force not yet", 32'(tinit_start), 0);
    tick();
    chk("init force done", 32'(tinit_start), 1);
    force_stop = 1'b0;

    // Randomized run against the behavioural model
    rst_n = 1'b0;
    tinit_val = 16'($urandom_range(0, 7));
    lane_cfg = 2'($urandom);
    hs_val = 8'($urandom_range(0, 5));
    decr = 1'b0; cfg_update = 1'b0; fifo_empty = 1'b1;
    model_reset();
    tick(); rst_n = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      cfg_update = ($urandom_range(0, 11) == 0);
      if (cfg_update) lane_cfg = 2'($urandom);
      force_stop = ($urandom_range(0, 19) == 0);
      fifo_empty = 1'($urandom);
      if ($urandom_range(0, 7) == 0) decr = ~decr;
      if ($urandom_range(0, 15) == 0) hs_val = 8'($urandom_range(0, 5));
      case ($urandom_range(0, 2))
        0: stopstate = 8'hFF;
        1: stopstate = 8'hFF ^ 8'(1 << $urandom_range(0, 7));
        default: stopstate = 8'($urandom);
      endcase
      tx_done = 1'($urandom);
      #1;
      model_check(cyc);
      m_prev_init = (m_phase == P_INIT);
      model_advance();
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
